// File: rtl/zmc_intc_pkg.sv
// Shared definitions for the zmc interrupt controller: register map, FSM states
// and the VECTOR register layout.
package zmc_intc_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ID_W    = 4;
   localparam int unsigned MAX_SRC = 16;

   localparam logic [1:0] OFS_CTRL    = 2'd0;
   localparam logic [1:0] OFS_ENABLE  = 2'd1;
   localparam logic [1:0] OFS_PENDING = 2'd2;
   localparam logic [1:0] OFS_VECTOR  = 2'd3;

   localparam int unsigned CTRL_GEN_BIT  = 0;
   localparam int unsigned VEC_INSVC_BIT = 15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   // VECTOR read layout: in-service flag on top, source id in the low nibble.
   typedef struct packed {
      logic                            insvc;
      logic [DATA_W-ID_W-2:0]          rsvd;
      logic [ID_W-1:0]                 id;
   } vector_t;

endpackage : zmc_intc_pkg

// File: rtl/zmc_intc_prio_enc.sv
// Lowest-index-wins priority encoder over the masked pending vector.
module zmc_intc_prio_enc
   import zmc_intc_pkg::*;
#(
   parameter int unsigned N_SRC = 8
)(
   input  logic [N_SRC-1:0] req_i,
   output logic [ID_W-1:0]  id_o,
   output logic             valid_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      id_o    = '0;
      valid_o = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            id_o    = ID_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule : zmc_intc_prio_enc

// File: rtl/zmc_intc.sv
// zmc interrupt controller: edge-latched sources, fixed-priority request/ack
// handshake to the core, Wishbone register block. ZMC_INTC_SYNC_EN adds input synchronizers.
module zmc_intc
   import zmc_intc_pkg::*;
#(
   parameter int unsigned N_SRC    = 8,
   parameter logic [15:0] BASE_ADR = 16'hFF00
)(
   input  logic              clk,
   input  logic              reset_h,
   input  logic [N_SRC-1:0]  irq_src_h,
   output logic              intr_h,
   input  logic              intr_ack_h,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [15:0]       wb_adr_i,
   input  logic [15:0]       wb_dat_i,
   output logic [15:0]       wb_dat_o,
   output logic              wb_ack_o
);

   logic [N_SRC-1:0] src_smp;

`ifdef ZMC_INTC_SYNC_EN
   logic [N_SRC-1:0] sync1_q;
   logic [N_SRC-1:0] sync2_q;

   // Two-flop synchronizer for sources that are asynchronous to clk.
   always_ff @(posedge clk) begin
      if (reset_h) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_src_h;
         sync2_q <= sync1_q;
      end
   end

   assign src_smp = sync2_q;
`else
   assign src_smp = irq_src_h;
`endif

   state_e           state_q, state_d;
   logic             gen_q, gen_d;
   logic [N_SRC-1:0] en_q, en_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] prev_q, prev_d;
   logic [ID_W-1:0]  vid_q, vid_d;
   logic             intr_q, intr_d;
   logic             ack_q, ack_d;
   logic [15:0]      dat_q, dat_d;

   logic             wb_hit;
   logic             wb_acc;
   logic             wb_wr;
   logic             wb_rd;
   logic [1:0]       ofs;
   logic             eoi;
   logic [N_SRC-1:0] masked;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr;
   logic [ID_W-1:0]  win_id;
   logic             win_vld;
   vector_t          vec;
   logic [15:0]      rdata;
   logic             unused_dat;

   // A strobe held while ack is high is not accepted again, so every access takes two cycles.
   assign wb_hit = wb_cyc_i & wb_stb_i & (wb_adr_i[15:2] == BASE_ADR[15:2]);
   assign wb_acc = wb_hit & ~ack_q;
   assign wb_wr  = wb_acc & wb_we_i;
   assign wb_rd  = wb_acc & ~wb_we_i;
   assign ofs    = wb_adr_i[1:0];
   assign eoi    = wb_wr & (ofs == OFS_VECTOR);

   assign masked = pend_q & en_q;
   assign rise   = src_smp & ~prev_q;

   assign unused_dat = ^wb_dat_i;

   zmc_intc_prio_enc #(
      .N_SRC   (N_SRC)
   ) u_prio_enc (
      .req_i   (masked),
      .id_o    (win_id),
      .valid_o (win_vld)
   );

   // Register readback mux.
   always_comb begin
      vec       = '0;
      vec.insvc = (state_q == ST_SERVICE);
      vec.id    = vid_q;
      rdata     = '0;
      case (ofs)
         OFS_CTRL:    rdata[CTRL_GEN_BIT] = gen_q;
         OFS_ENABLE:  rdata = DATA_W'(en_q);
         OFS_PENDING: rdata = DATA_W'(pend_q);
         OFS_VECTOR:  rdata = vec;
         default:     rdata = '0;
      endcase
   end

   // Next-state: register writes, request FSM and pending bookkeeping.
   always_comb begin
      state_d = state_q;
      gen_d   = gen_q;
      en_d    = en_q;
      prev_d  = src_smp;
      vid_d   = vid_q;
      clr     = '0;
      ack_d   = wb_acc;
      dat_d   = wb_rd ? rdata : 16'h0000;

      if (wb_wr) begin
         case (ofs)
            OFS_CTRL:    gen_d = wb_dat_i[CTRL_GEN_BIT];
            OFS_ENABLE:  en_d  = wb_dat_i[N_SRC-1:0];
            OFS_PENDING: clr   = wb_dat_i[N_SRC-1:0];
            default:     ;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (gen_q && win_vld) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (!gen_q || !win_vld) begin
               state_d = ST_IDLE;
            end else if (intr_ack_h) begin
               state_d = ST_SERVICE;
               vid_d   = win_id;
               clr     = clr | (N_SRC'(1) << win_id);
            end
         end
         ST_SERVICE: begin
            if (eoi) begin
               state_d = ST_IDLE;
               vid_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A fresh edge beats any clear landing in the same cycle.
      pend_d = (pend_q & ~clr) | rise;
      intr_d = (state_d == ST_REQ);
   end

   always_ff @(posedge clk) begin
      if (reset_h) begin
         state_q <= ST_IDLE;
         gen_q   <= 1'b0;
         en_q    <= '0;
         pend_q  <= '0;
         prev_q  <= '0;
         vid_q   <= '0;
         intr_q  <= 1'b0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         gen_q   <= gen_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
         prev_q  <= prev_d;
         vid_q   <= vid_d;
         intr_q  <= intr_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
      end
   end

   assign intr_h   = intr_q;
   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;

endmodule : zmc_intc
